// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: x - y - z, producing difference and borrow-out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic z,
   output logic difference,
   output logic borrow
);

   assign difference = x ^ y ^ z;
   assign borrow     = (~x & y) | (~(x ^ y) & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes (a - b) mod 2^WIDTH one bit per cycle, LSB first.
module serial_subtractor
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] difference,
   output logic             borrow
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nx;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-2:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_bw;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow;
   logic             w_dbit;
   logic             w_bout;
   logic             w_last;
   logic [WIDTH-1:0] w_cat;

   full_subtractor u_fs (
      .x          (r_a_sr[0]),
      .y          (r_b_sr[0]),
      .z          (r_bw),
      .difference (w_dbit),
      .borrow     (w_bout)
   );

   assign w_last = (r_cnt == CW'(WIDTH - 1));
   // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
   assign w_cat  = {w_dbit, r_res};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_IDLE:  if (start)  w_state_nx = ST_SHIFT;
         ST_SHIFT: if (w_last) w_state_nx = ST_DONE;
         ST_DONE:  w_state_nx = ST_IDLE;
         default:  w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_res    <= '0;
         r_cnt    <= '0;
         r_bw     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else begin
         r_busy <= (w_state_nx == ST_SHIFT);
         r_done <= (r_state == ST_SHIFT) && w_last;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a_sr <= a;
                  r_b_sr <= b;
                  r_res  <= '0;
                  r_bw   <= 1'b0;
                  r_cnt  <= '0;
               end
            end
            ST_SHIFT: begin
               r_a_sr <= r_a_sr >> 1;
               r_b_sr <= r_b_sr >> 1;
               r_res  <= w_cat[WIDTH-1:1];
               r_bw   <= w_bout;
               r_cnt  <= r_cnt + CW'(1);
               if (w_last) begin
                  r_diff   <= w_cat;
                  r_borrow <= w_bout;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign difference = r_diff;
   assign borrow     = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=8 and WIDTH=4.
module tb_serial_subtractor;

   logic       clock = 1'b0;
   logic       reset8, reset4;
   logic       start8, start4;
   logic [7:0] a8, b8;
   logic [3:0] a4, b4;
   logic       busy8, done8, borrow8;
   logic       busy4, done4, borrow4;
   logic [7:0] difference8;
   logic [3:0] difference4;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clock(clock), .reset(reset8), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .difference(difference8), .borrow(borrow8)
   );

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clock(clock), .reset(reset4), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .difference(difference4), .borrow(borrow4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One WIDTH=8 operation; optionally re-pulses start with other operands at busy cycle inj_k.
   task automatic op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                      input int inj_k, input logic [7:0] ed, input logic eb);
      int first, nd, nb;
      logic [7:0] gd;
      logic gb;
      first = -1; nd = 0; nb = 0; gd = '0; gb = 1'b0;
      @(negedge clock);
      a8 = ia; b8 = ib; start8 = 1'b1;
      @(negedge clock);
      start8 = 1'b0;
      if (busy8) nb++;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clock);
         if (busy8) nb++;
         if (done8) begin
            nd++;
            if (first < 0) begin
               first = k; gd = difference8; gb = borrow8;
            end
         end
         start8 = (k == inj_k);
         if (k == inj_k) begin
            a8 = 8'h55; b8 = 8'h22;
         end
      end
      start8 = 1'b0;
      check({tag, "_latency"}, 32'(first), 32'd8);
      check({tag, "_ndone"},   32'(nd),    32'd1);
      check({tag, "_nbusy"},   32'(nb),    32'd8);
      check({tag, "_diff"},    32'(gd),    32'(ed));
      check({tag, "_borrow"},  32'(gb),    32'(eb));
   endtask

   initial begin
      int nd, cnt;
      logic [3:0] ea, eb4;
      reset8 = 1'b1; reset4 = 1'b1;
      start8 = 1'b0; start4 = 1'b0;
      a8 = '0; b8 = '0; a4 = '0; b4 = '0;
      repeat (3) @(negedge clock);
      reset8 = 1'b0; reset4 = 1'b0;
      @(negedge clock);
      check("rst_busy",   32'(busy8),       32'd0);
      check("rst_done",   32'(done8),       32'd0);
      check("rst_diff",   32'(difference8), 32'd0);
      check("rst_borrow", 32'(borrow8),     32'd0);
      check("rst4_diff",  32'(difference4), 32'd0);

      op8("basic",     8'h5A, 8'h1F, 0, 8'h3B, 1'b0);
      op8("underflow", 8'h00, 8'h01, 0, 8'hFF, 1'b1);
      op8("equal",     8'hFF, 8'hFF, 0, 8'h00, 1'b0);
      op8("ignored",   8'h10, 8'h01, 3, 8'h0F, 1'b0);
      check("hold_diff", 32'(difference8), 32'h0F);

      // Reset mid-operation
      @(negedge clock);
      a8 = 8'h5A; b8 = 8'h1F; start8 = 1'b1;
      @(negedge clock);
      start8 = 1'b0;
      repeat (4) @(negedge clock);
      reset8 = 1'b1;
      #1;
      check("midrst_busy",   32'(busy8),       32'd0);
      check("midrst_done",   32'(done8),       32'd0);
      check("midrst_diff",   32'(difference8), 32'd0);
      check("midrst_borrow", 32'(borrow8),     32'd0);
      @(negedge clock);
      reset8 = 1'b0;
      nd = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         if (done8 || busy8) nd++;
      end
      check("midrst_quiet", 32'(nd), 32'd0);
      op8("after_rst", 8'h03, 8'h05, 0, 8'hFE, 1'b1);

      // Exhaustive WIDTH=4, start held high
      @(negedge clock);
      a4 = 4'd0; b4 = 4'd0; start4 = 1'b1;
      for (int i = 0; i < 256; i++) begin
         ea  = 4'(i >> 4);
         eb4 = 4'(i);
         cnt = 0;
         do begin
            @(negedge clock);
            cnt++;
         end while (!done4 && cnt < 12);
         check("ex_done",   32'(done4),       32'd1);
         check("ex_period", 32'(cnt),         (i == 0) ? 32'd5 : 32'd6);
         check("ex_diff",   32'(difference4), 32'(4'(ea - eb4)));
         check("ex_borrow", 32'(borrow4),     32'(ea < eb4));
         if (i == 255) start4 = 1'b0;
         else begin
            a4 = 4'((i + 1) >> 4);
            b4 = 4'(i + 1);
         end
      end
      repeat (8) @(negedge clock);
      check("ex_idle", 32'(busy4), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
